// File: rtl/booth_mult_seq_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN
  } booth_state_t;

  // Step counter runs 0..WIDTH, so it needs enough bits for WIDTH+1 values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/ready/done handshake and operand/result bus of the Booth multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 valid;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicador;
  logic [WIDTH-1:0]     multiplicando;
  logic                 ready;
  logic                 busy;
  logic [2*WIDTH-1:0]   Mult;
  logic                 done;

  modport master (
    output valid, signed_mode, multiplicador, multiplicando,
    input  ready, busy, Mult, done
  );

  modport slave (
    input  valid, signed_mode, multiplicador, multiplicando,
    output ready, busy, Mult, done
  );
endinterface

// File: rtl/booth_mult_seq_step.sv
// One radix-2 Booth iteration: add/subtract M by {Q[0],q_-1}, then arithmetic shift right.
module booth_step #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] q,
  input  logic         qm1,
  input  logic [N-1:0] m,
  output logic [N-1:0] a_nx,
  output logic [N-1:0] q_nx,
  output logic         qm1_nx
);
  logic [N-1:0] sum;

  always_comb begin
    case ({q[0], qm1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_nx   = {sum[N-1], sum[N-1:1]};
    q_nx   = {sum[0], q[N-1:1]};
    qm1_nx = q[0];
  end
endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned at runtime, optional edge-qualified start.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EDGE_START = 1'b1
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  booth_mult_seq_if.slave  bus
);
  localparam int N  = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  booth_state_t       state;
  logic [N-1:0]       a_r, q_r, m_r;
  logic               qm1_r;
  logic [N-1:0]       a_nx, q_nx;
  logic               qm1_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mult_r;
  logic               done_r;
  logic               valid_q;
  logic               start_ok;

  always_comb start_ok = bus.valid && (!EDGE_START || !valid_q);

  booth_step #(.N(N)) u_step (
    .a      (a_r),
    .q      (q_r),
    .qm1    (qm1_r),
    .m      (m_r),
    .a_nx   (a_nx),
    .q_nx   (q_nx),
    .qm1_nx (qm1_nx)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state   <= IDLE;
      a_r     <= '0;
      q_r     <= '0;
      m_r     <= '0;
      qm1_r   <= 1'b0;
      cnt     <= '0;
      mult_r  <= '0;
      done_r  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.valid;
      done_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            // Extension to N bits makes one Booth datapath serve both signed and unsigned.
            m_r   <= {bus.signed_mode & bus.multiplicando[WIDTH-1], bus.multiplicando};
            q_r   <= {bus.signed_mode & bus.multiplicador[WIDTH-1], bus.multiplicador};
            a_r   <= '0;
            qm1_r <= 1'b0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_nx;
          q_r   <= q_nx;
          qm1_r <= qm1_nx;
          if (cnt == CW'(N - 1)) begin
            mult_r <= {a_nx[WIDTH-2:0], q_nx};
            done_r <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.Mult  = mult_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed table, random, handshake corners, WIDTH=4 sweep.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_seq_if #(.WIDTH(8)) b8e ();
  booth_mult_seq_if #(.WIDTH(8)) b8l ();
  booth_mult_seq_if #(.WIDTH(4)) b4 ();

  booth_mult_seq #(.WIDTH(8), .EDGE_START(1'b1)) u8e (.CLK100MHZ(clk), .reset(rst), .bus(b8e.slave));
  booth_mult_seq #(.WIDTH(8), .EDGE_START(1'b0)) u8l (.CLK100MHZ(clk), .reset(rst), .bus(b8l.slave));
  booth_mult_seq #(.WIDTH(4), .EDGE_START(1'b0)) u4  (.CLK100MHZ(clk), .reset(rst), .bus(b4.slave));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        s;
    logic [7:0]  q;
    logic [7:0]  m;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] q, input logic [7:0] m);
    int qi, mi;
    qi = s ? int'($signed(q)) : int'(q);
    mi = s ? int'($signed(m)) : int'(m);
    return 16'(qi * mi);
  endfunction

  function automatic logic [7:0] ref4(input logic s, input logic [3:0] q, input logic [3:0] m);
    int qi, mi;
    qi = s ? int'($signed(q)) : int'(q);
    mi = s ? int'($signed(m)) : int'(m);
    return 8'(qi * mi);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or after a 50-cycle bound).
  task automatic op8(input logic s, input logic [7:0] q, input logic [7:0] m,
                     output logic [15:0] p, output int lat, output logic [15:0] mid);
    int k = 0;
    while (!b8e.ready && k < 50) begin @(negedge clk); k++; end
    b8e.signed_mode   = s;
    b8e.multiplicador = q;
    b8e.multiplicando = m;
    b8e.valid         = 1'b1;
    @(negedge clk);
    b8e.valid = 1'b0;
    lat = 0;
    mid = '0;
    while (!b8e.done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 4) mid = b8e.Mult;
    end
    p = b8e.Mult;
  endtask

  task automatic op4(input logic s, input logic [3:0] q, input logic [3:0] m, output logic [7:0] p);
    int k = 0;
    int lat = 0;
    while (!b4.ready && k < 50) begin @(negedge clk); k++; end
    b4.signed_mode   = s;
    b4.multiplicador = q;
    b4.multiplicando = m;
    b4.valid         = 1'b1;
    @(negedge clk);
    b4.valid = 1'b0;
    while (!b4.done && lat < 50) begin @(negedge clk); lat++; end
    p = b4.Mult;
  endtask

  initial begin
    logic [15:0] p, mid, prev;
    logic [7:0]  p4;
    int          lat;
    int          dones;
    int          tq[$];
    logic [15:0] pq[$];
    logic        rs;
    logic [7:0]  rq, rm;

    tbl[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    tbl[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl[2] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    tbl[3] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl[4] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    tbl[5] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
    tbl[6] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
    tbl[7] = '{1'b0, 8'h80, 8'h02, 16'h0100};

    {b8e.valid, b8e.signed_mode, b8e.multiplicador, b8e.multiplicando} = '0;
    {b8l.valid, b8l.signed_mode, b8l.multiplicador, b8l.multiplicando} = '0;
    {b4.valid, b4.signed_mode, b4.multiplicador, b4.multiplicando}     = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(b8e.ready), 32'd1);
    chk("rst_busy",  32'(b8e.busy),  32'd0);
    chk("rst_done",  32'(b8e.done),  32'd0);
    chk("rst_mult",  32'(b8e.Mult),  32'd0);
    chk("rst_ready_l", 32'(b8l.ready), 32'd1);
    chk("rst_mult_w4", 32'(b4.Mult),   32'd0);

    for (int i = 0; i < 8; i++) begin
      prev = b8e.Mult;
      op8(tbl[i].s, tbl[i].q, tbl[i].m, p, lat, mid);
      chk("tbl_latency", 32'(lat), 32'd9);
      chk("tbl_hold_mid_run", 32'(mid), 32'(prev));
      chk("tbl_product", 32'(p), 32'(tbl[i].exp));
    end

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      rq = 8'($urandom);
      rm = 8'($urandom);
      op8(rs, rq, rm, p, lat, mid);
      chk("rand_product", 32'(p), 32'(ref8(rs, rq, rm)));
    end

    // Edge-start: valid held high, with a 0->1 toggle while busy that must be lost.
    @(negedge clk);
    dones = 0;
    b8e.signed_mode = 1'b0; b8e.multiplicador = 8'd6; b8e.multiplicando = 8'd7;
    b8e.valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) b8e.valid = 1'b0;
      if (c == 3) b8e.valid = 1'b1;
      if (c == 5) chk("edge_busy_ignore_ready", 32'(b8e.ready), 32'd0);
      if (b8e.done) dones++;
    end
    chk("edge_single_done", 32'(dones), 32'd1);
    chk("edge_product", 32'(b8e.Mult), 32'd42);
    b8e.valid = 1'b0;
    repeat (2) @(negedge clk);

    // Level-start: back-to-back products; operands changed mid-run apply only to the next one.
    b8l.signed_mode = 1'b0; b8l.multiplicador = 8'd3; b8l.multiplicando = 8'd4;
    b8l.valid = 1'b1;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (c == 4) begin
        b8l.signed_mode = 1'b1; b8l.multiplicador = 8'hF0; b8l.multiplicando = 8'h05;
      end
      if (b8l.done) begin tq.push_back(c); pq.push_back(b8l.Mult); end
    end
    b8l.valid = 1'b0;
    chk("level_done_count", 32'(tq.size()), 32'd3);
    while (tq.size() < 3) begin tq.push_back(-100); pq.push_back('x); end
    chk("level_first_done", 32'(tq[0]), 32'd9);
    chk("level_period_1", 32'(tq[1] - tq[0]), 32'd10);
    chk("level_period_2", 32'(tq[2] - tq[1]), 32'd10);
    chk("level_prod_0", 32'(pq[0]), 32'(ref8(1'b0, 8'd3, 8'd4)));
    chk("level_prod_1", 32'(pq[1]), 32'(ref8(1'b1, 8'hF0, 8'h05)));
    chk("level_prod_2", 32'(pq[2]), 32'(ref8(1'b1, 8'hF0, 8'h05)));
    repeat (12) @(negedge clk);

    // Reset in the middle of a run.
    op8(1'b0, 8'd7, 8'd9, p, lat, mid);
    chk("pre_reset_product", 32'(p), 32'd63);
    b8e.signed_mode = 1'b1; b8e.multiplicador = 8'hFD; b8e.multiplicando = 8'h05;
    b8e.valid = 1'b1;
    @(negedge clk);
    b8e.valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(b8e.ready), 32'd1);
    chk("abort_busy",  32'(b8e.busy),  32'd0);
    chk("abort_done",  32'(b8e.done),  32'd0);
    chk("abort_mult",  32'(b8e.Mult),  32'd0);
    op8(1'b1, 8'hFD, 8'h05, p, lat, mid);
    chk("post_abort_product", 32'(p), 32'hFFF1);
    chk("post_abort_latency", 32'(lat), 32'd9);

    for (int unsigned s = 0; s < 2; s++)
      for (int unsigned q = 0; q < 16; q++)
        for (int unsigned m = 0; m < 16; m++) begin
          op4(1'(s), 4'(q), 4'(m), p4);
          chk("w4_sweep", 32'(p4), 32'(ref4(1'(s), 4'(q), 4'(m))));
        end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
